// File: rtl/ui888_565_dither.sv
// RGB888 to RGB565 converter with truncate, round or 4x4 ordered-dither reduction.
// Two-stage pipeline sharing one advance enable; output registers hold while stalled.
module ui888_565_dither #(
    parameter int DITHER_MODE = 2,
    parameter int H_ACTIVE    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_data,
    input  logic        s_sof,
    input  logic        s_eol,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_sof,
    output logic        m_eol
);

    localparam int              XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [1:0]      MODE   = 2'(DITHER_MODE);
    localparam logic [XW-1:0]   X_LAST = XW'(H_ACTIVE - 1);

    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] m;
        case ({row, col})
            4'd0:    m = 4'd0;
            4'd1:    m = 4'd8;
            4'd2:    m = 4'd2;
            4'd3:    m = 4'd10;
            4'd4:    m = 4'd12;
            4'd5:    m = 4'd4;
            4'd6:    m = 4'd14;
            4'd7:    m = 4'd6;
            4'd8:    m = 4'd3;
            4'd9:    m = 4'd11;
            4'd10:   m = 4'd1;
            4'd11:   m = 4'd9;
            4'd12:   m = 4'd15;
            4'd13:   m = 4'd7;
            4'd14:   m = 4'd13;
            4'd15:   m = 4'd5;
            default: m = 4'd0;
        endcase
        return m;
    endfunction

    // The carry into bit 8 means the channel overflowed and clips to full scale.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] off);
        logic [8:0] sum;
        sum = {1'b0, a} + {6'b000000, off};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic          en_s;
    logic          take_s;
    logic [XW-1:0] x_r;
    logic [1:0]    y_r;
    logic [XW-1:0] pos_x_s;
    logic [1:0]    pos_y_s;
    logic [XW-1:0] next_x_s;
    logic [1:0]    next_y_s;
    logic [3:0]    bayer_s;
    logic [2:0]    off_rb_s;
    logic [1:0]    off_g_s;

    logic          s1_valid_r;
    logic [23:0]   s1_data_r;
    logic          s1_sof_r;
    logic          s1_eol_r;
    logic [2:0]    s1_off_rb_r;
    logic [1:0]    s1_off_g_r;

    logic [7:0]    r_sat_s;
    logic [7:0]    g_sat_s;
    logic [7:0]    b_sat_s;
    logic [15:0]   pix565_s;

    assign en_s    = !m_valid || m_ready;
    assign s_ready = en_s;
    assign take_s  = s_valid && en_s;

    // Pixel position for the incoming pixel and the position that follows it.
    always_comb begin
        pos_x_s  = s_sof ? {XW{1'b0}} : x_r;
        pos_y_s  = s_sof ? 2'd0 : y_r;
        next_x_s = {XW{1'b0}};
        next_y_s = 2'd0;
        if (s_eol || (pos_x_s == X_LAST)) begin
            next_x_s = {XW{1'b0}};
            next_y_s = pos_y_s + 2'd1;
        end else begin
            next_x_s = pos_x_s + {{(XW-1){1'b0}}, 1'b1};
            next_y_s = pos_y_s;
        end
    end

    // Per-channel offsets selected by the reduction mode.
    always_comb begin
        bayer_s  = bayer(pos_y_s, pos_x_s[1:0]);
        off_rb_s = 3'd0;
        off_g_s  = 2'd0;
        case (MODE)
            2'd0: begin
                off_rb_s = 3'd0;
                off_g_s  = 2'd0;
            end
            2'd1: begin
                off_rb_s = 3'd4;
                off_g_s  = 2'd2;
            end
            default: begin
                off_rb_s = bayer_s[3:1];
                off_g_s  = bayer_s[3:2];
            end
        endcase
    end

    // Column and row-phase counters advance on accepted input pixels only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= {XW{1'b0}};
            y_r <= 2'd0;
        end else if (take_s) begin
            x_r <= next_x_s;
            y_r <= next_y_s;
        end
    end

    // Stage 1: capture pixel, flags and its offsets.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_data_r   <= 24'h000000;
            s1_sof_r    <= 1'b0;
            s1_eol_r    <= 1'b0;
            s1_off_rb_r <= 3'd0;
            s1_off_g_r  <= 2'd0;
        end else if (en_s) begin
            s1_valid_r <= s_valid;
            if (s_valid) begin
                s1_data_r   <= s_data;
                s1_sof_r    <= s_sof;
                s1_eol_r    <= s_eol;
                s1_off_rb_r <= off_rb_s;
                s1_off_g_r  <= off_g_s;
            end
        end
    end

    assign r_sat_s  = sat_add(s1_data_r[23:16], s1_off_rb_r);
    assign g_sat_s  = sat_add(s1_data_r[15:8], {1'b0, s1_off_g_r});
    assign b_sat_s  = sat_add(s1_data_r[7:0], s1_off_rb_r);
    assign pix565_s = {r_sat_s[7:3], g_sat_s[7:2], b_sat_s[7:3]};

    // Stage 2: registered output pixel and sideband flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 16'h0000;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
        end else if (en_s) begin
            m_valid <= s1_valid_r;
            if (s1_valid_r) begin
                m_data <= pix565_s;
                m_sof  <= s1_sof_r;
                m_eol  <= s1_eol_r;
            end
        end
    end

endmodule

// File: tb/tb_ui888_565_dither.sv
// Bench for ui888_565_dither: four configurations share one input stream and are
// checked every cycle against an arithmetic model, plus hand-computed pixel values.
module tb_ui888_565_dither;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [23:0] s_data = 24'h000000;
    logic        s_sof = 1'b0;
    logic        s_eol = 1'b0;
    logic        m_ready = 1'b1;

    logic        s_ready [4];
    logic        m_valid [4];
    logic [15:0] m_data  [4];
    logic        m_sof   [4];
    logic        m_eol   [4];

    int n_checks = 0;
    int n_pass   = 0;

    logic [17:0] exp_q [4][$];
    logic [15:0] got_q [4][$];
    int          mx [4];
    int          my [4];
    int          ha [4];
    int          md [4];
    logic        prev_stall [4];
    logic [17:0] prev_out [4];
    bit          bp_en = 1'b0;

    always #5 clk = ~clk;

    ui888_565_dither #(.DITHER_MODE(0), .H_ACTIVE(1024)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[0]), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid[0]), .m_ready(m_ready),
        .m_data(m_data[0]), .m_sof(m_sof[0]), .m_eol(m_eol[0]));
    ui888_565_dither #(.DITHER_MODE(1), .H_ACTIVE(1024)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[1]), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid[1]), .m_ready(m_ready),
        .m_data(m_data[1]), .m_sof(m_sof[1]), .m_eol(m_eol[1]));
    ui888_565_dither #(.DITHER_MODE(2), .H_ACTIVE(1024)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[2]), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid[2]), .m_ready(m_ready),
        .m_data(m_data[2]), .m_sof(m_sof[2]), .m_eol(m_eol[2]));
    ui888_565_dither #(.DITHER_MODE(2), .H_ACTIVE(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready[3]), .s_data(s_data),
        .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid[3]), .m_ready(m_ready),
        .m_data(m_data[3]), .m_sof(m_sof[3]), .m_eol(m_eol[3]));

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    function automatic logic [15:0] model_pix(input int mode, input logic [23:0] d,
                                              input int x, input int y);
        int bm [16];
        int m, orb, og, r, g, b;
        bm = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
        m = bm[(y % 4) * 4 + (x % 4)];
        if (mode == 0) begin orb = 0; og = 0; end
        else if (mode == 1) begin orb = 4; og = 2; end
        else begin orb = m / 2; og = m / 4; end
        r = int'(d[23:16]) + orb; if (r > 255) r = 255;
        g = int'(d[15:8]) + og;   if (g > 255) g = 255;
        b = int'(d[7:0]) + orb;   if (b > 255) b = 255;
        return 16'(((r / 8) << 11) | ((g / 4) << 5) | (b / 8));
    endfunction

    // Compare process: every falling edge, check outputs and feed the model.
    initial begin
        ha = '{1024, 1024, 1024, 4};
        md = '{0, 1, 2, 2};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!rst_n) begin
                    exp_q[i].delete();
                    mx[i] = 0; my[i] = 0; prev_stall[i] = 1'b0;
                    check("rst_m_valid", i, 32'(m_valid[i]), 32'd0);
                    check("rst_s_ready", i, 32'(s_ready[i]), 32'd1);
                    check("rst_m_out", i, 32'({m_sof[i], m_eol[i], m_data[i]}), 32'd0);
                end else begin
                    logic [17:0] act;
                    act = {m_sof[i], m_eol[i], m_data[i]};
                    check("s_ready", i, 32'(s_ready[i]), 32'(!(m_valid[i] && !m_ready)));
                    if (prev_stall[i]) begin
                        check("stall_valid", i, 32'(m_valid[i]), 32'd1);
                        check("stall_hold", i, 32'(act), 32'(prev_out[i]));
                    end
                    if (m_valid[i] && m_ready) begin
                        if (exp_q[i].size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_out dut%0d: got 0x%0h expected no pixel", i, act);
                        end else begin
                            check("out", i, 32'(act), 32'(exp_q[i].pop_front()));
                            got_q[i].push_back(m_data[i]);
                        end
                    end
                    prev_stall[i] = m_valid[i] && !m_ready;
                    prev_out[i] = act;
                    if (s_valid && s_ready[i]) begin
                        int px, py;
                        px = s_sof ? 0 : mx[i];
                        py = s_sof ? 0 : my[i];
                        exp_q[i].push_back({s_sof, s_eol, model_pix(md[i], s_data, px, py)});
                        if (s_eol || px == ha[i] - 1) begin mx[i] = 0; my[i] = (py + 1) % 4; end
                        else begin mx[i] = px + 1; my[i] = py; end
                    end
                end
            end
        end
    end

    // Downstream backpressure pattern 1,0,0,1 when enabled.
    initial begin
        int k = 0;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin m_ready = pat[k % 4]; k++; end
        end
    end

    task automatic send(input logic [23:0] d, input logic sof, input logic eol);
        int c;
        s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
        c = 0;
        @(negedge clk);
        while (!s_ready[0] && c < 100) begin @(negedge clk); c++; end
        if (c >= 100) begin
            n_checks++;
            $display("FAIL send_timeout dut0: got s_ready 0 expected 1 within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < 4; i++)
            if (exp_q[i].size() != 0 || m_valid[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain();
        idle();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (all_done()) break;
        end
        if (!all_done()) begin
            n_checks++;
            $display("FAIL drain_timeout dut0: got pending pixels expected none after 200 cycles");
        end
    endtask

    task automatic clear_got();
        for (int i = 0; i < 4; i++) got_q[i].delete();
    endtask

    logic [15:0] lit_a [4][6];
    logic [23:0] bp_px [8];

    initial begin
        lit_a = '{'{16'h83E7, 16'h83E7, 16'h83E7, 16'h83E7, 16'h83E7, 16'hF81F},
                  '{16'h8C08, 16'h8C08, 16'h8C08, 16'h8C08, 16'h8C08, 16'hF81F},
                  '{16'h83E7, 16'h8C08, 16'h83E7, 16'h8C08, 16'h8C08, 16'hF81F},
                  '{16'h83E7, 16'h8C08, 16'h83E7, 16'h8C08, 16'h8C08, 16'hF81F}};
        bp_px = '{24'h847F3C, 24'hFF00FF, 24'h000000, 24'h123456,
                  24'hF8FCF8, 24'h7F7F7F, 24'h0A0B0C, 24'hFFFFFF};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed pixels, latency and mode literals.
        clear_got();
        send(24'h847F3C, 1'b1, 1'b0);
        check("latency_stage1", 0, 32'(m_valid[0]), 32'd0);
        send(24'h847F3C, 1'b0, 1'b0);
        check("latency_valid", 0, 32'(m_valid[0]), 32'd1);
        check("latency_data", 0, 32'(m_data[0]), 32'h83E7);
        send(24'h847F3C, 1'b0, 1'b0);
        send(24'h847F3C, 1'b0, 1'b1);
        send(24'h847F3C, 1'b0, 1'b0);
        send(24'hFF00FF, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) begin
            check("a_count", i, 32'(got_q[i].size()), 32'd6);
            for (int j = 0; j < 6 && j < got_q[i].size(); j++)
                check("a_literal", i, 32'(got_q[i][j]), 32'(lit_a[i][j]));
        end

        // Backpressure stream.
        clear_got();
        bp_en = 1'b1;
        for (int j = 0; j < 8; j++) send(bp_px[j], 1'(j == 0), 1'(j == 3 || j == 7));
        drain();
        bp_en = 1'b0;
        @(posedge clk); #1 m_ready = 1'b1;
        for (int i = 0; i < 4; i++) check("bp_count", i, 32'(got_q[i].size()), 32'd8);

        // Forced column wrap without end-of-line.
        clear_got();
        for (int j = 0; j < 17; j++) send(24'h847F3C, 1'(j == 0), 1'b0);
        drain();
        if (got_q[3].size() == 17 && got_q[2].size() == 17) begin
            check("wrap_y1", 3, 32'(got_q[3][4]), 32'h8C08);
            check("wrap_y2", 3, 32'(got_q[3][8]), 32'h83E7);
            check("wrap_y3", 3, 32'(got_q[3][12]), 32'h8C08);
            check("wrap_y0", 3, 32'(got_q[3][16]), 32'h83E7);
            check("nowrap_x4", 2, 32'(got_q[2][4]), 32'h83E7);
        end else begin
            check("wrap_count", 3, 32'(got_q[3].size()), 32'd17);
            check("wrap_count", 2, 32'(got_q[2].size()), 32'd17);
        end

        // Mid-frame reset discards in-flight pixels and restarts at (0,0).
        for (int j = 0; j < 9; j++) send(24'h847F3C, 1'(j == 0), 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_async_valid", i, 32'(m_valid[i]), 32'd0);
            check("rst_async_ready", i, 32'(s_ready[i]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_got();
        send(24'h847F3C, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < 4; i++) check("post_rst_count", i, 32'(got_q[i].size()), 32'd1);
        if (got_q[3].size() == 1 && got_q[2].size() == 1 && got_q[1].size() == 1) begin
            check("post_rst_m0", 3, 32'(got_q[3][0]), 32'h83E7);
            check("post_rst_m0", 2, 32'(got_q[2][0]), 32'h83E7);
            check("post_rst_round", 1, 32'(got_q[1][0]), 32'h8C08);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
